// File: rtl/xy_sequence_driver_pkg.sv
// Shared constants for the x/y sequence-detect link: driver FSM encoding,
// detector latencies and the minimum hold length.
`timescale 1ns/1ps
package xy_sequence_driver_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_REPORT  = 2'd3;

  // Detector: one state step for y=0, two for y=1, plus the driver output register.
  localparam int unsigned LAT_Y0  = 2;
  localparam int unsigned LAT_Y1  = 3;
  localparam int unsigned MIN_LEN = 3;

endpackage

// File: rtl/xy_sequence_driver.sv
// Initiator for the x/y sequence detector: drives one request's sequence,
// measures the in_z rise latency, checks release/idle and reports via done.
`timescale 1ns/1ps
module xy_sequence_driver
  import xy_sequence_driver_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             start_mode,
  input  logic [LEN_W-1:0] start_len,
  output logic             out_x,
  output logic             out_y,
  input  logic             in_z,
  output logic             done,
  output logic             z_ok,
  output logic [LEN_W-1:0] z_lat
);

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic             rose_q, rose_d;
  logic             drop_q, drop_d;
  logic [LEN_W-1:0] lat_q, lat_d;
  logic             rel_q, rel_d;
  logic             x_q, x_d;
  logic             y_q, y_d;
  logic             done_q, done_d;
  logic             z_ok_q, z_ok_d;
  logic [LEN_W-1:0] z_lat_q, z_lat_d;
  logic [LEN_W-1:0] exp_lat;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    k_d     = k_q;
    rose_d  = rose_q;
    drop_d  = drop_q;
    lat_d   = lat_q;
    rel_d   = rel_q;
    done_d  = 1'b0;
    z_ok_d  = z_ok_q;
    z_lat_d = z_lat_q;
    exp_lat = mode_q ? LEN_W'(LAT_Y1) : LEN_W'(LAT_Y0);

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          mode_d  = start_mode;
          len_d   = (start_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : start_len;
          k_d     = LEN_W'(1);
          rose_d  = 1'b0;
          drop_d  = 1'b0;
          lat_d   = '0;
          rel_d   = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (in_z && !rose_q) begin
          rose_d = 1'b1;
          lat_d  = k_q;
        end
        if (!in_z && rose_q) drop_d = 1'b1;
        if (k_q == len_q) state_d = ST_RELEASE;
        else              k_d     = k_q + LEN_W'(1);
      end
      ST_RELEASE: begin
        rel_d   = in_z;
        state_d = ST_REPORT;
      end
      ST_REPORT: begin
        z_ok_d  = (lat_q == exp_lat) && !drop_q && rel_q && !in_z;
        z_lat_d = lat_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they follow the next state rather than the current one.
    x_d = (state_d == ST_DRIVE);
    y_d = x_d && mode_d;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      len_q   <= '0;
      k_q     <= '0;
      rose_q  <= 1'b0;
      drop_q  <= 1'b0;
      lat_q   <= '0;
      rel_q   <= 1'b0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      done_q  <= 1'b0;
      z_ok_q  <= 1'b0;
      z_lat_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      k_q     <= k_d;
      rose_q  <= rose_d;
      drop_q  <= drop_d;
      lat_q   <= lat_d;
      rel_q   <= rel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      z_ok_q  <= z_ok_d;
      z_lat_q <= z_lat_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign out_x       = x_q;
  assign out_y       = y_q;
  assign done        = done_q;
  assign z_ok        = z_ok_q;
  assign z_lat       = z_lat_q;

endmodule
